// File: rtl/wish_blinky_pkg.sv
// Shared types and sizing helpers for the Wishbone pattern-blinker bank.
package wish_blinky_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REPEAT,
    ONESHOT
  } ch_state_e;

  // Bit position of the ONESHOT flag on writes and of BUSY on reads.
  function automatic int flag_bit(input int mask_w);
    return mask_w;
  endfunction

  function automatic int addr_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: holds a pattern and shifts it out MSB-first on each tick,
// either forever (REPEAT) or once with a completion pulse (ONESHOT).
module blinky_channel
  import wish_blinky_pkg::*;
#(
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [MASK_W:0]   wr_data,
  output logic [MASK_W-1:0] mask,
  output logic              busy,
  output logic              led,
  output logic              done
);

  localparam int PW = $clog2(MASK_W) + 1;
  localparam logic [PW-1:0] POS_END = PW'(MASK_W);

  ch_state_e         state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [MASK_W-1:0] mask_d;
  logic              led_d, done_d;
  logic [MASK_W-1:0] mask_rot;

  assign mask_rot = {mask[MASK_W-2:0], mask[MASK_W-1]};
  assign busy     = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block is given a default first so that no path leaves it unassigned (no latch).
    state_d = state_q;
    mask_d  = mask;
    pos_d   = pos_q;
    led_d   = led;
    done_d  = 1'b0;
    if (wr_en) begin
      // A write on a tick edge wins; that tick is simply lost for this channel.
      mask_d  = wr_data[MASK_W-1:0];
      pos_d   = '0;
      led_d   = 1'b0;
      state_d = wr_data[flag_bit(MASK_W)] ? ONESHOT : REPEAT;
    end else if (tick) begin
      case (state_q)
        REPEAT: begin
          led_d  = mask[MASK_W-1];
          mask_d = mask_rot;
          pos_d  = (pos_q == POS_END) ? pos_q : pos_q + PW'(1);
        end
        ONESHOT: begin
          if (pos_q < POS_END) begin
            led_d  = mask[MASK_W-1];
            mask_d = mask_rot;
            pos_d  = pos_q + PW'(1);
          end else begin
            led_d   = 1'b0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: led_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the pattern register is a handful of flops, not a RAM, so it is reset along with the control state.
    if (!rst_n) begin
      state_q <= IDLE;
      mask    <= '0;
      pos_q   <= '0;
      led     <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q <= state_d;
      mask    <= mask_d;
      pos_q   <= pos_d;
      led     <= led_d;
      done    <= done_d;
    end
  end

endmodule

// File: rtl/wish_blinky_bank.sv
// Multi-channel pattern blinker with a Wishbone-style slave port; holds the
// shared prescaler, address decode and the ACK/readback path.
module wish_blinky_bank
  import wish_blinky_pkg::*;
#(
  parameter  int NUM_CH          = 4,
  parameter  int MASK_W          = 8,
  parameter  int SYSCLK_DIV_BITS = 22,
  localparam int AW              = addr_width(NUM_CH)
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic              WE_I,
  input  logic [AW-1:0]     ADR_I,
  input  logic [MASK_W:0]   DAT_I,
  output logic [MASK_W:0]   DAT_O,
  output logic              ACK_O,
  output logic [NUM_CH-1:0] o_led,
  output logic [NUM_CH-1:0] o_done,
  output logic              o_alive
);

  logic [SYSCLK_DIV_BITS-1:0] presc;
  logic                       tick;
  logic                       xfer;
  logic [MASK_W:0]            rd_data;
  logic [MASK_W-1:0]          ch_mask [NUM_CH];
  logic [NUM_CH-1:0]          ch_busy;

  assign tick    = &presc;
  assign o_alive = presc[SYSCLK_DIV_BITS-1];
  // A transfer is accepted only while ACK_O is low, so a held STB_I yields one every other clock.
  assign xfer    = STB_I & ~ACK_O;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) presc <= '0;
    else        presc <= presc + SYSCLK_DIV_BITS'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    blinky_channel #(.MASK_W(MASK_W)) u_ch (
      .clk     (CLK_I),
      .rst_n   (RST_I),
      .tick    (tick),
      .wr_en   (xfer & WE_I & (ADR_I == AW'(g))),
      .wr_data (DAT_I),
      .mask    (ch_mask[g]),
      .busy    (ch_busy[g]),
      .led     (o_led[g]),
      .done    (o_done[g])
    );
  end

  // Addresses beyond NUM_CH-1 match no channel and read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ADR_I == AW'(i)) rd_data = {ch_busy[i], ch_mask[i]};
  end

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      ACK_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= xfer;
      if (xfer && !WE_I) DAT_O <= rd_data;
    end
  end

endmodule

// File: tb/tb_wish_blinky_bank.sv
// Directed scoreboard bench for wish_blinky_bank (4-channel and 3-channel builds).
module tb_wish_blinky_bank;

  localparam int DIV = 3;
  localparam int MW  = 8;
  localparam logic [7:0] PAT1 = 8'hA0;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  logic       stb = 1'b0, we = 1'b0;
  logic [1:0] adr = '0;
  logic [8:0] dat = '0;
  logic [8:0] dat_o;
  logic       ack, alive;
  logic [3:0] led, done;

  logic       stb3 = 1'b0, we3 = 1'b0;
  logic [1:0] adr3 = '0;
  logic [8:0] dat3 = '0;
  logic [8:0] dat_o3;
  logic       ack3, alive3;
  logic [2:0] led3, done3;

  wish_blinky_bank #(.NUM_CH(4), .MASK_W(MW), .SYSCLK_DIV_BITS(DIV)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(stb), .WE_I(we), .ADR_I(adr),
    .DAT_I(dat), .DAT_O(dat_o), .ACK_O(ack), .o_led(led), .o_done(done),
    .o_alive(alive)
  );

  wish_blinky_bank #(.NUM_CH(3), .MASK_W(MW), .SYSCLK_DIV_BITS(DIV)) dut3 (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(stb3), .WE_I(we3), .ADR_I(adr3),
    .DAT_I(dat3), .DAT_O(dat_o3), .ACK_O(ack3), .o_led(led3), .o_done(done3),
    .o_alive(alive3)
  );

  // Independent prescaler model: counts ticks since reset release.
  logic [DIV-1:0] tb_cnt = '0;
  int             tick_n = 0;
  always @(posedge CLK_I) begin
    if (!RST_I) tb_cnt <= '0;
    else begin
      tb_cnt <= tb_cnt + 1'b1;
      if (tb_cnt == '1) tick_n <= tick_n + 1;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   base1 = 0;
  int   acks  = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: got %0h required a queued expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: got %0h required %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input bit on3, input bit w, input logic [1:0] a, input logic [8:0] d);
    @(negedge CLK_I);
    if (on3) begin stb3 = 1'b1; we3 = w; adr3 = a; dat3 = d; end
    else     begin stb  = 1'b1; we  = w; adr  = a; dat  = d; end
    @(posedge CLK_I); #1;
  endtask

  task automatic release_bus();
    @(negedge CLK_I);
    stb  = 1'b0;
    stb3 = 1'b0;
    @(posedge CLK_I); #1;
  endtask

  task automatic wr(input bit on3, input logic [1:0] a, input logic [8:0] d);
    push(on3 ? "ack_wr3" : "ack_wr", 32'd1);
    drive(on3, 1'b1, a, d);
    check(32'(on3 ? ack3 : ack));
    release_bus();
  endtask

  task automatic rd(input bit on3, input logic [1:0] a, input logic [8:0] exp_d);
    push(on3 ? "ack_rd3" : "ack_rd", 32'd1);
    push(on3 ? "dat_o3" : "dat_o", 32'(exp_d));
    drive(on3, 1'b0, a, 9'h000);
    check(32'(on3 ? ack3 : ack));
    check(32'(on3 ? dat_o3 : dat_o));
    release_bus();
  endtask

  task automatic wait_tick();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge CLK_I);
      if (tb_cnt == '1) hit = 1'b1;
    end
    if (hit) begin
      @(posedge CLK_I); #1;
    end else begin
      n_chk++;
      n_err++;
      $display("FAIL tick_timeout: got no tick required one within 20 clocks");
    end
  endtask

  function automatic logic led1_at(input int j);
    logic [7:0] p;
    p = PAT1;
    if (j <= 0) return 1'b0;
    return p[7 - ((j - 1) % 8)];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish within 10000 clocks");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p2;
    bit         hit;

    // Power-on reset held for 3 clocks.
    push("rst_led", 32'd0); push("rst_done", 32'd0); push("rst_ack", 32'd0);
    push("rst_dat_o", 32'd0); push("rst_alive", 32'd0); push("rst_dat_o3", 32'd0);
    repeat (3) @(posedge CLK_I);
    #1;
    check(32'(led)); check(32'(done)); check(32'(ack));
    check(32'(dat_o)); check(32'(alive)); check(32'(dat_o3));
    @(negedge CLK_I);
    RST_I = 1'b1;

    // ch1 REPEAT 1010_0000: two full rotations.
    wr(1'b0, 2'd1, {1'b0, PAT1});
    base1 = tick_n;
    for (int j = 1; j <= 16; j++) push("led_repeat", 32'({2'b00, led1_at(j), 1'b0}));
    for (int j = 1; j <= 16; j++) begin
      wait_tick();
      check(32'(led));
    end
    push("alive", 32'(tb_cnt[DIV-1]));
    check(32'(alive));

    // ch2 ONESHOT 1100_0001: 8 bits shown, done on tick 9, then idle.
    wr(1'b0, 2'd2, 9'h1C1);
    p2 = 8'hC1;
    for (int k = 0; k < 8; k++) begin
      push("led2_oneshot", 32'(p2[7 - k]));
      push("done2_early", 32'd0);
    end
    push("led2_end", 32'd0);
    push("done2_pulse", 32'd1);
    for (int k = 0; k < 9; k++) begin
      wait_tick();
      check(32'(led[2]));
      check(32'(done[2]));
    end
    push("done2_width", 32'd0);
    @(posedge CLK_I); #1;
    check(32'(done[2]));
    rd(1'b0, 2'd2, 9'h0C1);

    // STB_I held 6 clocks: ACK_O on alternate edges, 3 transfers.
    @(negedge CLK_I);
    stb = 1'b1; we = 1'b1; adr = 2'd0; dat = 9'h081;
    acks = 0;
    for (int e = 0; e < 6; e++) push("ack_held", 32'((e % 2) == 0));
    for (int e = 0; e < 6; e++) begin
      @(posedge CLK_I); #1;
      check(32'(ack));
      if (ack) acks++;
    end
    @(negedge CLK_I);
    stb = 1'b0;
    push("ack_count", 32'd3);
    check(32'(acks));
    @(posedge CLK_I); #1;

    // ch3 written on a tick edge: tick lost for ch3, ch1 still rotates.
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge CLK_I);
      if (tb_cnt == '1) hit = 1'b1;
    end
    if (!hit) begin
      n_chk++;
      n_err++;
      $display("FAIL tick_align: got no tick phase required one within 20 clocks");
    end
    stb = 1'b1; we = 1'b1; adr = 2'd3; dat = 9'h0F0;
    push("ack_on_tick", 32'd1);
    push("led3_on_tick", 32'd0);
    @(posedge CLK_I); #1;
    push("led1_on_tick", 32'(led1_at(tick_n - base1)));
    check(32'(ack)); check(32'(led[3])); check(32'(led[1]));
    release_bus();
    rd(1'b0, 2'd3, 9'h1F0);
    push("led3_first", 32'd1);
    wait_tick();
    check(32'(led[3]));
    push("led1_next", 32'(led1_at(tick_n - base1)));
    check(32'(led[1]));

    // 3-channel build: address 3 acknowledged but ignored.
    wr(1'b1, 2'd3, 9'h1FF);
    push("led3ch_idle", 32'd0);
    check(32'(led3));
    rd(1'b1, 2'd3, 9'h000);
    rd(1'b1, 2'd0, 9'h000);
    rd(1'b1, 2'd2, 9'h000);
    wr(1'b1, 2'd0, 9'h055);
    rd(1'b1, 2'd0, 9'h155);

    // Reset mid-pattern: everything clears, no completion pulse.
    wr(1'b0, 2'd2, 9'h1FF);
    wait_tick();
    wait_tick();
    push("led2_mid", 32'd1);
    check(32'(led[2]));
    @(negedge CLK_I);
    RST_I = 1'b0;
    for (int c = 0; c < 3; c++) begin
      push("rst_mid_done", 32'd0);
      push("rst_mid_led", 32'd0);
      @(posedge CLK_I); #1;
      check(32'(done));
      check(32'(led));
    end
    push("rst_mid_ack", 32'd0); push("rst_mid_dat_o", 32'd0); push("rst_mid_alive", 32'd0);
    check(32'(ack)); check(32'(dat_o)); check(32'(alive));
    @(negedge CLK_I);
    RST_I = 1'b1;
    rd(1'b0, 2'd1, 9'h000);
    rd(1'b0, 2'd2, 9'h000);
    push("done_after_rst", 32'd0);
    wait_tick();
    check(32'(done));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wish_blinky_bank.md
# wish_blinky_bank

Multi-channel, parametrised pattern blinker with a Wishbone-style slave port. Each of NUM_CH channels holds a MASK_W-bit on/off pattern that it shifts out MSB-first to its LED at a shared prescaled tick rate, either repeating forever or once (one-shot, with a completion pulse). It replaces the single-channel 8-bit blinker and adds addressed channel writes, readback, ACK_O handshaking and the one-shot mode. It sits between the bus master and the board LEDs.

## Interface
Parameters:
- NUM_CH, 4: number of LED channels, 1..16.
- MASK_W, 8: pattern width per channel, 2..32.
- SYSCLK_DIV_BITS, 22: prescaler width; tick period is 2^SYSCLK_DIV_BITS clocks.

Ports:
- CLK_I  in  1  system clock; all state updates on rising edge.
- RST_I  in  1  reset, synchronous, active-low.
- STB_I  in  1  slave select / transfer request.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  AW  channel index, AW = max(1, clog2(NUM_CH)).
- DAT_I  in  MASK_W+1  [MASK_W-1:0] pattern, [MASK_W] ONESHOT flag.
- DAT_O  out  MASK_W+1  read data: [MASK_W-1:0] current rotated mask, [MASK_W] BUSY.
- ACK_O  out  1  transfer acknowledge, registered.
- o_led  out  NUM_CH  LED drive per channel, active-high.
- o_done  out  NUM_CH  one-clock pulse when a one-shot pattern completes.
- o_alive  out  1  prescaler MSB, heartbeat.

## Operation
- Prescaler: free-running SYSCLK_DIV_BITS-bit counter, +1 every clock, wraps. tick = counter == all-ones. Never reset by bus activity; shared by all channels.
- Per-channel state: IDLE, REPEAT, ONESHOT; mask register, position counter pos (clog2(MASK_W)+1 bits), led register.
- Write (STB_I=1, WE_I=1, ACK_O=0, ADR_I < NUM_CH): target channel loads mask = DAT_I[MASK_W-1:0], pos = 0, led = 0; state = ONESHOT if DAT_I[MASK_W] else REPEAT. Other channels unaffected.
- Read (WE_I=0): DAT_O = {BUSY, mask} of addressed channel; BUSY = state != IDLE.
- Tick in REPEAT/ONESHOT (pos < MASK_W): led = mask[MASK_W-1]; mask rotates left by 1; pos += 1.
- Tick in ONESHOT with pos == MASK_W: led = 0, state = IDLE, o_done pulses that clock. Mask equals original pattern again (full rotation).
- REPEAT: pos saturates/wraps irrelevantly; rotation continues forever. Mask 0 in REPEAT is legal (LED stays off, BUSY=1).
- IDLE: ticks ignored; led held 0.
- Out-of-range ADR_I (NUM_CH not power of 2): ACK_O still given, write ignored, DAT_O = 0.
- Write and tick same cycle, same channel: write wins, tick discarded for that channel only.
- Reset (RST_I=0 at edge): prescaler 0, all channels IDLE, mask 0, pos 0, o_led 0, o_done 0, ACK_O 0, DAT_O 0; o_alive 0. Reset mid-pattern aborts without o_done.

## Timing
- ACK_O: set on the edge where STB_I=1 and ACK_O=0; cleared next edge unconditionally. Held STB_I yields one transfer every 2 clocks. Master deasserts STB_I after sampling ACK_O.
- Write commits on the same edge ACK_O rises. DAT_O valid in the ACK_O-high cycle, captured on that edge; holds last value otherwise.
- First LED update after a write: next tick, i.e. 1..2^SYSCLK_DIV_BITS clocks later (prescaler phase not realigned).
- o_led changes only on tick edges or write/reset edges (led=0). o_done is exactly 1 clock wide, coincident with the tick edge.
- One-shot total: MASK_W ticks showing bits, then done on tick MASK_W+1.

## Structure
- Package wish_blinky_pkg: state encoding enum (IDLE, REPEAT, ONESHOT), ONESHOT/BUSY bit-position function of MASK_W, AW computation function.
- Sub-module blinky_channel (parameter MASK_W): per-channel state, mask, pos, led, done; inputs tick, wr_en, wr_data. Instantiated NUM_CH times via generate. Top holds prescaler, address decode, ACK/readback mux.

## Test plan
All with SYSCLK_DIV_BITS=3 (tick every 8 clocks), MASK_W=8, NUM_CH=4.
- Reset held 3 clocks mid-pattern -> all outputs 0, DAT_O read of any channel = 0, no o_done.
- Write ch1 = 8'b1010_0000 REPEAT -> ACK_O 1 clock after STB_I; o_led[1] over successive ticks 1,0,1,0,0,0,0,0, repeating; other LEDs 0.
- Write ch2 = 8'b1100_0001 ONESHOT -> o_led[2] 1,1,0,0,0,0,0,1 then 0 on 9th tick with o_done[2] single pulse; read ch2 -> DAT_O = {0, 8'hC1}.
- STB_I held 6 clocks writing ch0 -> exactly 3 ACK_O pulses, alternating cycles.
- Write ch3 on the exact tick edge -> ch3 shows pos=0 afterward (tick lost), ch1 rotates normally same edge.
- NUM_CH=3 variant, write ADR_I=3 -> ACK_O given, no channel changes, read returns 0.
